// File: rtl/axis_frame_gen_64_if.sv
// axis_frame_gen_64_if: AXI-Stream bundle between the frame source and its sink
`timescale 1ns/1ps
interface axis_frame_gen_64_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_gen_64.sv
// axis_frame_gen_64: synthetic AXI-Stream frame source with programmable length, count, gap and error injection
`timescale 1ns/1ps
module axis_frame_gen_64 #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = 8,
    parameter int TX_USER_WIDTH = 1,
    parameter int LEN_WIDTH     = 16,
    parameter int GAP_WIDTH     = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [LEN_WIDTH-1:0] cfg_frame_len,
    input  logic [CNT_WIDTH-1:0] cfg_frame_count,
    input  logic [GAP_WIDTH-1:0] cfg_gap_cycles,
    input  logic                 cfg_err_inject,
    axis_frame_gen_64_if.master  m_axis,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic [CNT_WIDTH-1:0] bytes_sent
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam logic [KEEP_WIDTH-1:0] ALL_ON = '1;
    state_t state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
    logic [31:0] beat, seq;
    logic stop_pend, err_pend;
    logic hs, stop_eff, done, load, new_frame, ld_last;
    logic [LEN_WIDTH-1:0] ld_len;
    logic [LEN_WIDTH:0] ld_beats;
    logic [31:0] ld_k, ld_seq;
    logic [KEEP_WIDTH-1:0] ld_keep;
    logic [2:0] rem;
    // ld_* describe the beat that goes onto the bus whenever load is asserted
    always_comb begin
        hs = m_axis.tvalid & m_axis.tready;
        stop_eff = stop_pend | stop;
        done = stop_eff || (count_q != '0 && frames_sent + CNT_WIDTH'(1) == count_q);
        load = (state == IDLE) ? (start && cfg_frame_len != '0)
             : (state == SEND) ? (hs && (!m_axis.tlast || (!done && gap_q == '0)))
             : (state == GAP)  ? (!stop_eff && gap_cnt == GAP_WIDTH'(1)) : 1'b0;
        new_frame = state != SEND || m_axis.tlast;
        ld_len = (state == IDLE) ? cfg_frame_len : len_q;
        ld_beats = ({1'b0, ld_len} + (LEN_WIDTH+1)'(7)) >> 3;
        ld_k = new_frame ? 32'd1 : beat + 32'd1;
        ld_seq = (state == IDLE) ? 32'd0 : new_frame ? seq + 32'd1 : seq;
        ld_last = ld_k == 32'(ld_beats);
        rem = ld_len[2:0];
        ld_keep = (ld_last && rem != 3'd0) ? ~(ALL_ON << rem) : ALL_ON;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
            count_q <= '0;
            gap_q <= '0;
            gap_cnt <= '0;
            beat <= '0;
            seq <= '0;
            stop_pend <= 1'b0;
            err_pend <= 1'b0;
            busy <= 1'b0;
            frames_sent <= '0;
            bytes_sent <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata <= '0;
            m_axis.tkeep <= '0;
            m_axis.tlast <= 1'b0;
            m_axis.tuser <= '0;
        end else begin
            stop_pend <= (state != IDLE) && stop_eff;
            // a pending error is consumed only by the last beat that actually carried it
            err_pend <= (err_pend && !(hs && m_axis.tlast && m_axis.tuser[0])) || cfg_err_inject;
            if (hs) bytes_sent <= bytes_sent + CNT_WIDTH'($countones(m_axis.tkeep));
            if (hs && m_axis.tlast) frames_sent <= frames_sent + CNT_WIDTH'(1);
            if (load) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tdata <= DATA_WIDTH'({ld_seq, ld_k});
                m_axis.tkeep <= ld_keep;
                m_axis.tlast <= ld_last;
                m_axis.tuser <= TX_USER_WIDTH'(ld_last && (err_pend || cfg_err_inject));
                beat <= ld_k;
                seq <= ld_seq;
            end else if (hs) m_axis.tvalid <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    state <= SEND;
                    busy <= 1'b1;
                    len_q <= cfg_frame_len;
                    count_q <= cfg_frame_count;
                    gap_q <= cfg_gap_cycles;
                    frames_sent <= '0;
                    bytes_sent <= '0;
                end
                SEND: if (hs && m_axis.tlast && !load) begin
                    state <= done ? IDLE : GAP;
                    busy <= !done;
                    gap_cnt <= gap_q;
                end
                GAP: if (stop_eff) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (load) state <= SEND;
                else gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_gen_64.sv
// tb_axis_frame_gen_64: directed self-checking bench for the AXI-Stream frame generator
`timescale 1ns/1ps
module tb_axis_frame_gen_64;
    logic clk = 0, rst_n = 0, start = 0, stop = 0, err = 0;
    logic [15:0] len = 0;
    logic [31:0] cnt = 0;
    logic [7:0] gap = 0;
    logic busy;
    logic [31:0] frames_sent, bytes_sent;
    int checks = 0, errors = 0;
    axis_frame_gen_64_if ax();
    axis_frame_gen_64 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_frame_len(len), .cfg_frame_count(cnt), .cfg_gap_cycles(gap), .cfg_err_inject(err),
        .m_axis(ax), .busy(busy), .frames_sent(frames_sent), .bytes_sent(bytes_sent)
    );
    always #5 clk = ~clk;
    logic [63:0] q_data[$];
    logic [7:0] q_keep[$];
    logic q_last[$], q_user[$];
    int idle_cycles = 0, stab_err = 0;
    logic prev_stall = 0;
    logic [73:0] held = '0;
    // records accepted beats, counts idle cycles inside a run and flags payload changes while stalled
    always @(posedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && (!ax.tvalid || {ax.tdata, ax.tkeep, ax.tlast, ax.tuser} != held)) stab_err++;
            if (ax.tvalid && ax.tready) begin
                q_data.push_back(ax.tdata);
                q_keep.push_back(ax.tkeep);
                q_last.push_back(ax.tlast);
                q_user.push_back(ax.tuser[0]);
            end
            if (busy && !ax.tvalid) idle_cycles++;
            prev_stall = ax.tvalid && !ax.tready;
            held = {ax.tdata, ax.tkeep, ax.tlast, ax.tuser};
        end
    end
    task automatic clear_mon();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        q_user.delete();
        idle_cycles = 0;
        stab_err = 0;
    endtask
    task automatic kick(input logic [15:0] l, input logic [31:0] c, input logic [7:0] g);
        @(negedge clk);
        len = l;
        cnt = c;
        gap = g;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask
    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: busy=%0b required 0", name, busy); end
    endtask
    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        checks++; if (ax.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", ax.tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (frames_sent !== 0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        checks++; if (bytes_sent !== 0) begin errors++; $display("FAIL reset_bytes: got %0d want 0", bytes_sent); end
        checks++; if (ax.tdata !== 64'h0 || ax.tkeep !== 8'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", ax.tdata, ax.tkeep); end
    endtask
    task automatic test_single();
        clear_mon();
        kick(16'd8, 32'd1, 8'd0);
        checks++; if (ax.tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_first: valid=%0b busy=%0b want 1/1", ax.tvalid, busy); end
        checks++; if (ax.tdata !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL single_data: got %h want 0000000000000001", ax.tdata); end
        checks++; if (ax.tkeep !== 8'hFF || ax.tlast !== 1'b1 || ax.tuser !== 1'b0) begin errors++; $display("FAIL single_ctl: keep=%h last=%0b user=%0b want ff/1/0", ax.tkeep, ax.tlast, ax.tuser); end
        @(negedge clk);
        checks++; if (ax.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: valid=%0b busy=%0b want 0/0", ax.tvalid, busy); end
        checks++; if (frames_sent !== 1 || bytes_sent !== 8) begin errors++; $display("FAIL single_cnt: frames=%0d bytes=%0d want 1/8", frames_sent, bytes_sent); end
    endtask
    task automatic test_gap();
        logic [63:0] want;
        clear_mon();
        kick(16'd64, 32'd2, 8'd3);
        // a second start with different config mid-run must change nothing
        len = 16'd8;
        cnt = 32'd1;
        gap = 8'd0;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle("gap");
        checks++; if (q_data.size() !== 16) begin errors++; $display("FAIL gap_beats: got %0d want 16", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            want = {32'(i / 8), 32'(i % 8 + 1)};
            checks++; if (q_data[i] !== want) begin errors++; $display("FAIL gap_data[%0d]: got %h want %h", i, q_data[i], want); end
        end
        checks++; if (q_data.size() == 16 && (q_last[7] !== 1'b1 || q_last[15] !== 1'b1 || q_last[6] !== 1'b0)) begin errors++; $display("FAIL gap_last: got %0b%0b%0b want 011", q_last[6], q_last[7], q_last[15]); end
        checks++; if (idle_cycles !== 3) begin errors++; $display("FAIL gap_idle: got %0d want 3", idle_cycles); end
        checks++; if (frames_sent !== 2 || bytes_sent !== 128) begin errors++; $display("FAIL gap_cnt: frames=%0d bytes=%0d want 2/128", frames_sent, bytes_sent); end
    endtask
    task automatic test_back_to_back();
        logic [63:0] want[4];
        want = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0002};
        clear_mon();
        @(negedge clk);
        len = 16'd16;
        cnt = 32'd2;
        gap = 8'd0;
        start = 1;
        stop = 1;
        @(negedge clk);
        start = 0;
        stop = 0;
        wait_idle("b2b");
        checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL b2b_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 4; i++) begin
            checks++; if (q_data[i] !== want[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, q_data[i], want[i]); end
        end
        checks++; if (idle_cycles !== 0) begin errors++; $display("FAIL b2b_idle: got %0d want 0", idle_cycles); end
        checks++; if (frames_sent !== 2 || bytes_sent !== 32) begin errors++; $display("FAIL b2b_cnt: frames=%0d bytes=%0d want 2/32", frames_sent, bytes_sent); end
    endtask
    task automatic test_keep();
        clear_mon();
        kick(16'd13, 32'd1, 8'd0);
        wait_idle("keep13");
        checks++; if (q_data.size() !== 2) begin errors++; $display("FAIL keep13_beats: got %0d want 2", q_data.size()); end
        checks++; if (q_data.size() == 2 && (q_keep[0] !== 8'hFF || q_keep[1] !== 8'h1F)) begin errors++; $display("FAIL keep13_keep: got %h,%h want ff,1f", q_keep[0], q_keep[1]); end
        checks++; if (q_data.size() == 2 && (q_last[0] !== 1'b0 || q_last[1] !== 1'b1)) begin errors++; $display("FAIL keep13_last: got %0b%0b want 01", q_last[0], q_last[1]); end
        checks++; if (bytes_sent !== 13) begin errors++; $display("FAIL keep13_bytes: got %0d want 13", bytes_sent); end
        clear_mon();
        kick(16'd16, 32'd1, 8'd0);
        wait_idle("keep16");
        checks++; if (q_data.size() !== 2 || q_keep[1] !== 8'hFF || q_last[1] !== 1'b1) begin errors++; $display("FAIL keep16: beats=%0d keep=%h want 2/ff", q_data.size(), q_keep[1]); end
        clear_mon();
        kick(16'd1, 32'd1, 8'd0);
        wait_idle("keep1");
        checks++; if (q_data.size() !== 1 || q_keep[0] !== 8'h01 || bytes_sent !== 1) begin errors++; $display("FAIL keep1: beats=%0d keep=%h bytes=%0d want 1/01/1", q_data.size(), q_keep[0], bytes_sent); end
    endtask
    task automatic test_stall();
        int n = 0;
        logic [63:0] want;
        clear_mon();
        @(negedge clk);
        len = 16'd40;
        cnt = 32'd3;
        gap = 8'd1;
        start = 1;
        ax.tready = 0;
        do begin
            @(negedge clk);
            start = 0;
            ax.tready = 1'($urandom_range(0, 1));
            n++;
        end while (busy && n < 2000);
        ax.tready = 1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_timeout: busy=%0b required 0", busy); end
        checks++; if (q_data.size() !== 15) begin errors++; $display("FAIL stall_beats: got %0d want 15", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 15; i++) begin
            want = {32'(i / 5), 32'(i % 5 + 1)};
            checks++; if (q_data[i] !== want) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, q_data[i], want); end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stab_err); end
        checks++; if (idle_cycles !== 2) begin errors++; $display("FAIL stall_idle: got %0d want 2", idle_cycles); end
        checks++; if (frames_sent !== 3 || bytes_sent !== 120) begin errors++; $display("FAIL stall_cnt: frames=%0d bytes=%0d want 3/120", frames_sent, bytes_sent); end
    endtask
    task automatic test_stop_err();
        int n = 0;
        clear_mon();
        kick(16'd24, 32'd0, 8'd2);
        while (frames_sent != 1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (frames_sent !== 1) begin errors++; $display("FAIL stop_wait1: frames=%0d required 1", frames_sent); end
        err = 1;
        @(negedge clk);
        err = 0;
        n = 0;
        while (!(ax.tvalid && ax.tdata == 64'h0000_0002_0000_0001) && n < 200) begin @(negedge clk); n++; end
        checks++; if (ax.tdata !== 64'h0000_0002_0000_0001) begin errors++; $display("FAIL stop_wait3: tdata=%h required 0000000200000001", ax.tdata); end
        stop = 1;
        @(negedge clk);
        stop = 0;
        wait_idle("stop");
        checks++; if (frames_sent !== 3 || bytes_sent !== 72) begin errors++; $display("FAIL stop_cnt: frames=%0d bytes=%0d want 3/72", frames_sent, bytes_sent); end
        checks++; if (q_data.size() !== 9) begin errors++; $display("FAIL stop_beats: got %0d want 9", q_data.size()); end
        checks++; if (q_data.size() == 9 && (q_data[8] !== 64'h0000_0002_0000_0003 || q_last[8] !== 1'b1)) begin errors++; $display("FAIL stop_tail: got %h last=%0b want 0000000200000003/1", q_data[8], q_last[8]); end
        for (int i = 0; i < q_user.size() && i < 9; i++) begin
            checks++; if (q_user[i] !== 1'(i == 5)) begin errors++; $display("FAIL stop_user[%0d]: got %0b want %0b", i, q_user[i], i == 5); end
        end
    endtask
    task automatic test_reset_mid();
        kick(16'd64, 32'd0, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checks++; if (ax.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_out: valid=%0b busy=%0b want 0/0", ax.tvalid, busy); end
        checks++; if (frames_sent !== 0 || bytes_sent !== 0) begin errors++; $display("FAIL rstmid_cnt: frames=%0d bytes=%0d want 0/0", frames_sent, bytes_sent); end
        rst_n = 1;
        kick(16'd0, 32'd1, 8'd0);
        checks++; if (ax.tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len0_start: valid=%0b busy=%0b want 0/0", ax.tvalid, busy); end
        @(negedge clk);
        checks++; if (ax.tvalid !== 1'b0) begin errors++; $display("FAIL len0_later: valid=%0b want 0", ax.tvalid); end
    endtask
    initial begin
        ax.tready = 1;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_keep();
        test_stall();
        test_stop_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
